apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, number of ACCESS cycles with pready low before forced error; 0 disables the timeout.
REQ-002 SHALL have ports clock input 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset input 1, asynchronous active-high reset.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: request handshake.
REQ-005 SHALL have ports req_addr input 32, req_write input 1, req_wdata input 32, req_wstrb input 4, req_prot input 3: request payload.
REQ-006 SHALL have ports resp_valid output 1, resp_ready input 1, resp_rdata output 32, resp_err output 1: response handshake and payload.
REQ-007 SHALL have APB4 master outputs out_paddr 32, out_psel 1, out_penable 1, out_pprot 3, out_pwrite 1, out_pwdata 32, out_pstrb 4.
REQ-008 SHALL have APB4 master inputs out_pready 1, out_prdata 32, out_pslverr 1.

Function
REQ-009 SHALL implement states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only (no input-to-output combinational path).
REQ-010 IDLE: req_ready=1, all other states req_ready=0; on req_valid&&req_ready capture payload, go SETUP next cycle.
REQ-011 SETUP: out_psel=1, out_penable=0; unconditionally ACCESS next cycle.
REQ-012 ACCESS: out_psel=1, out_penable=1; wait-state counter clears on entry, increments each cycle with out_pready=0.
REQ-013 ACCESS with out_pready=1: latch resp_err=out_pslverr, resp_rdata=out_prdata for reads, 0 for writes; go RESP.
REQ-014 ACCESS with out_pready=0, TIMEOUT!=0, counter==TIMEOUT-1: go RESP, resp_err=1, resp_rdata=0; out_psel/out_penable drop next cycle.
REQ-015 out_pready=1 in the timeout cycle: completion per REQ-013 wins; no timeout error.
REQ-016 RESP: resp_valid=1, out_psel=0, out_penable=0; resp_rdata/resp_err stable until resp_ready=1, then IDLE.
REQ-017 out_paddr, out_pwrite, out_pprot, out_pwdata constant from SETUP through last ACCESS cycle; retain last value outside a transfer.
REQ-018 out_pstrb = captured req_wstrb for writes, 4'b0000 for reads.
REQ-019 out_pslverr and out_prdata ignored except in the ACCESS cycle with out_pready=1.
REQ-020 Minimum transfer: request accept to resp_valid = 3 cycles (IDLE->SETUP->ACCESS->RESP), throughput one transfer per 4 cycles with resp_ready held high.
REQ-021 Wait-state counter 16 bits wide; TIMEOUT > 65536 clamps to 65536.
REQ-022 req_valid in non-IDLE states SHALL be ignored and not captured.

Reset
REQ-023 reset=1 SHALL asynchronously force state IDLE, clear counter, and drive out_psel=0, out_penable=0, out_paddr=0, out_pwrite=0, out_pprot=0, out_pwdata=0, out_pstrb=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-024 req_ready SHALL be 0 while reset=1 and 1 the first cycle after release.
REQ-025 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abort it: psel drops immediately, no response issued after release.

Verification
REQ-026 Write 0x8000_0010 data 0xDEADBEEF strb 0xF, slave pready=1 in first ACCESS -> SETUP then ACCESS with pwrite=1, pstrb=0xF; resp_valid 3 cycles after accept, resp_err=0, resp_rdata=0.
REQ-027 Read 0x8000_0020, slave 2 wait states then pready=1, prdata=0x12345678 -> paddr stable 4 cycles, pstrb=0, resp_rdata=0x12345678, resp_err=0.
REQ-028 Read, slave returns pready=1 pslverr=1 -> resp_err=1, resp_rdata=slave prdata.
REQ-029 TIMEOUT=4, slave pready held 0 -> exactly 4 ACCESS cycles, then RESP with resp_err=1, resp_rdata=0, psel=0; with pready=1 on 4th cycle -> normal completion, resp_err=0.
REQ-030 resp_ready held 0 for 5 cycles with req_valid=1 -> resp_valid/data stable, req_ready=0, no new SETUP until response taken.
REQ-031 reset asserted in ACCESS -> psel, penable, resp_valid 0 in same cycle; after release req_ready=1, no stale response.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Turns a single-beat request/response interface into APB4 master transfers.
// Only one transfer is in flight at a time. Every transfer walks
// IDLE -> SETUP -> ACCESS (held while the slave inserts wait states) -> RESP.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The sender holds valid and the payload steady until then.
// The bridge drives req_ready high only in IDLE. It drives resp_valid in RESP
// and keeps resp_rdata/resp_err stable there until resp_ready is seen.
//
// Ports
//   clock, reset             single rising-edge clock, async active-high reset
//   req_valid / req_ready    request handshake
//   req_addr, req_write, req_wdata, req_wstrb, req_prot   request payload
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     response payload
//   out_p*                   APB4 master bus (paddr/psel/penable/pprot/pwrite/
//                            pwdata/pstrb out; pready/prdata/pslverr in)
//   state_dbg                current FSM state (IDLE=0 SETUP=1 ACCESS=2 RESP=3)
module apb_master_bridge #(
  parameter int TIMEOUT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_prot,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The wait counter is 16 bits, so very large timeouts saturate at 65536.
  localparam int          TLIM  = (TIMEOUT > 65536) ? 65536 : ((TIMEOUT < 0) ? 0 : TIMEOUT);
  localparam bit          TO_EN = (TLIM != 0);
  localparam logic [15:0] TLAST = TO_EN ? 16'(TLIM - 1) : 16'd0;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        accept;
  logic        done;
  logic        expire;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign done   = (state == ACCESS) && out_pready;
  // A slave that answers in the last allowed cycle still completes normally.
  assign expire = (state == ACCESS) && !out_pready && TO_EN && (wait_cnt == TLAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || expire) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered so it reads 0 during reset and rises on the first edge after
  // release; otherwise it tracks "state is IDLE" exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) req_ready <= 1'b0;
    else       req_ready <= (state_nxt == IDLE);
  end

  // Bus payload is captured once at accept and held until the next accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_paddr  <= 32'd0;
      out_pwrite <= 1'b0;
      out_pprot  <= 3'd0;
      out_pwdata <= 32'd0;
      out_pstrb  <= 4'd0;
    end else if (accept) begin
      out_paddr  <= req_addr;
      out_pwrite <= req_write;
      out_pprot  <= req_prot;
      out_pwdata <= req_wdata;
      out_pstrb  <= req_write ? req_wstrb : 4'd0;
    end
  end

  // Cleared in SETUP so it starts from zero on the first ACCESS cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               wait_cnt <= 16'd0;
    else if (state == SETUP)                 wait_cnt <= 16'd0;
    else if ((state == ACCESS) && !out_pready) wait_cnt <= wait_cnt + 16'd1;
  end

  // The slave's prdata/pslverr are sampled only in the completing ACCESS cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (done) begin
      resp_rdata <= out_pwrite ? 32'd0 : out_prdata;
      resp_err   <= out_pslverr;
    end else if (expire) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b1;
    end
  end

  assign out_psel    = (state == SETUP) || (state == ACCESS);
  assign out_penable = (state == ACCESS);
  assign resp_valid  = (state == RESP);
  assign state_dbg   = state;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_prot = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;
  logic [1:0]  state_dbg;

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_prot(req_prot),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- counters / scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];   // {resp_err, resp_rdata}

  // ---------------- APB slave model ----------------
  // In ACCESS cycle k (k=0 first) pready = (k >= slave_waits) unless hanging.
  // prdata/pslverr carry junk whenever pready is low.
  int          slave_waits = 0;
  bit          slave_hang = 1'b0;
  bit          slave_err = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          acc_cnt = 0;

  always @(negedge clock) begin
    if (out_psel && out_penable) begin
      out_pready  = !slave_hang && (acc_cnt >= slave_waits);
      out_prdata  = out_pready ? slave_rdata : $urandom;
      out_pslverr = out_pready ? slave_err : 1'($urandom_range(0, 1));
      acc_cnt++;
    end else begin
      acc_cnt     = 0;
      out_pready  = 1'b0;
      out_prdata  = $urandom;
      out_pslverr = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  // Starts and ends just after a falling edge. Returns at the SETUP cycle.
  task automatic send_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input logic [32:0] e);
    int g = 0;
    req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; req_prot = p;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && g < 50) begin @(negedge clock); g++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL req_accept: req_ready=%b required 1", req_ready); end
    exp_q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for resp_valid while recording the bus as seen in SETUP/ACCESS.
  // lat counts cycles since accept.
  task automatic wait_resp(output int lat, output int psel_n, output int acc_n, output bit stable,
                           output logic [31:0] s_addr, output logic s_write, output logic [3:0] s_strb,
                           output logic [31:0] s_wdata, output logic [2:0] s_prot);
    lat = 1; psel_n = 0; acc_n = 0; stable = 1'b1;
    s_addr = 'x; s_write = 'x; s_strb = 'x; s_wdata = 'x; s_prot = 'x;
    while (resp_valid !== 1'b1 && lat < 300) begin
      if (out_psel === 1'b1) begin
        if (psel_n == 0) begin
          s_addr = out_paddr; s_write = out_pwrite; s_strb = out_pstrb;
          s_wdata = out_pwdata; s_prot = out_pprot;
        end else if ({out_paddr, out_pwrite, out_pstrb, out_pwdata, out_pprot} !==
                     {s_addr, s_write, s_strb, s_wdata, s_prot}) begin
          stable = 1'b0;
        end
        psel_n++;
        if (out_penable === 1'b1) acc_n++;
      end
      @(negedge clock);
      lat++;
    end
  endtask

  // Samples the response in RESP, pops the expected value, then takes it.
  task automatic take_resp(output logic [32:0] got, output logic [32:0] exp_v);
    got = {resp_err, resp_rdata};
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clock); @(negedge clock);
    n_cmp++; if ({out_psel, out_penable, resp_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_ctrl: psel/penable/resp_valid=%b required 000", {out_psel, out_penable, resp_valid}); end
    n_cmp++; if ({out_paddr, out_pwdata, out_pwrite, out_pprot, out_pstrb} !== 72'd0) begin n_bad++; $display("FAIL rst_bus: addr=%h wdata=%h write=%b prot=%h strb=%h required all 0", out_paddr, out_pwdata, out_pwrite, out_pprot, out_pstrb); end
    n_cmp++; if ({resp_err, resp_rdata} !== 33'd0) begin n_bad++; $display("FAIL rst_resp: err=%b rdata=%h required 0/0", resp_err, resp_rdata); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_held: req_ready=%b required 0", req_ready); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL rst_state: state=%0d required 0", state_dbg); end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_release: req_ready=%b required 1", req_ready); end
  endtask

  task automatic test_write();
    int lat, pn, an; bit st; logic [31:0] sa, sd; logic sw; logic [3:0] ss; logic [2:0] sp;
    logic [32:0] got, e;
    slave_waits = 0; slave_hang = 0; slave_err = 0; slave_rdata = 32'hA5A5_A5A5;
    send_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, {1'b0, 32'h0});
    wait_resp(lat, pn, an, st, sa, sw, ss, sd, sp);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d required 3", lat); end
    n_cmp++; if (pn !== 2 || an !== 1) begin n_bad++; $display("FAIL wr_phases: psel cycles %0d access cycles %0d required 2/1", pn, an); end
    n_cmp++; if ({sa, sw, ss, sd, sp} !== {32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 3'b010}) begin n_bad++; $display("FAIL wr_bus: addr=%h write=%b strb=%h wdata=%h prot=%h", sa, sw, ss, sd, sp); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL wr_stable: stable=%b required 1", st); end
    take_resp(got, e);
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL wr_resp: got %h required %h", got, e); end
  endtask

  task automatic test_read_wait();
    int lat, pn, an; bit st; logic [31:0] sa, sd; logic sw; logic [3:0] ss; logic [2:0] sp;
    logic [32:0] got, e;
    slave_waits = 2; slave_hang = 0; slave_err = 0; slave_rdata = 32'h1234_5678;
    send_req(32'h8000_0020, 1'b0, 32'hFFFF_0000, 4'hF, 3'b001, {1'b0, 32'h1234_5678});
    wait_resp(lat, pn, an, st, sa, sw, ss, sd, sp);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL rd_latency: got %0d required 5", lat); end
    n_cmp++; if (pn !== 4 || st !== 1'b1 || sa !== 32'h8000_0020) begin n_bad++; $display("FAIL rd_addr_stable: psel cycles %0d stable %b addr %h required 4/1/80000020", pn, st, sa); end
    n_cmp++; if ({sw, ss} !== 5'b0_0000) begin n_bad++; $display("FAIL rd_strb: write=%b strb=%h required 0/0", sw, ss); end
    take_resp(got, e);
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL rd_resp: got %h required %h", got, e); end
  endtask

  task automatic test_slverr();
    int lat, pn, an; bit st; logic [31:0] sa, sd; logic sw; logic [3:0] ss; logic [2:0] sp;
    logic [32:0] got, e;
    slave_waits = 1; slave_hang = 0; slave_err = 1; slave_rdata = 32'hCAFE_F00D;
    send_req(32'h0000_0104, 1'b0, 32'h0, 4'h0, 3'b000, {1'b1, 32'hCAFE_F00D});
    wait_resp(lat, pn, an, st, sa, sw, ss, sd, sp);
    take_resp(got, e);
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL slverr_resp: got %h required %h", got, e); end
    slave_err = 0;
  endtask

  task automatic test_timeout();
    int lat, pn, an; bit st; logic [31:0] sa, sd; logic sw; logic [3:0] ss; logic [2:0] sp;
    logic [32:0] got, e;
    slave_hang = 1; slave_err = 0; slave_rdata = 32'h7777_7777;
    send_req(32'h0000_0200, 1'b0, 32'h0, 4'h0, 3'b000, {1'b1, 32'h0});
    wait_resp(lat, pn, an, st, sa, sw, ss, sd, sp);
    n_cmp++; if (an !== TO || lat !== TO + 2) begin n_bad++; $display("FAIL to_access_cycles: access %0d latency %0d required %0d/%0d", an, lat, TO, TO + 2); end
    n_cmp++; if ({out_psel, out_penable} !== 2'b00) begin n_bad++; $display("FAIL to_psel_drop: psel/penable=%b required 00", {out_psel, out_penable}); end
    take_resp(got, e);
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL to_resp: got %h required %h", got, e); end
    // Ready on the last allowed cycle: normal completion wins.
    slave_hang = 0; slave_waits = TO - 1; slave_rdata = 32'h0BAD_CAFE;
    send_req(32'h0000_0204, 1'b0, 32'h0, 4'h0, 3'b000, {1'b0, 32'h0BAD_CAFE});
    wait_resp(lat, pn, an, st, sa, sw, ss, sd, sp);
    n_cmp++; if (an !== TO) begin n_bad++; $display("FAIL to_edge_cycles: access %0d required %0d", an, TO); end
    take_resp(got, e);
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL to_edge_resp: got %h required %h", got, e); end
  endtask

  task automatic test_backpressure();
    int lat, pn, an; bit st; logic [31:0] sa, sd; logic sw; logic [3:0] ss; logic [2:0] sp;
    logic [32:0] got, e;
    slave_waits = 0; slave_hang = 0; slave_err = 0; slave_rdata = 32'h1122_3344;
    send_req(32'h8000_0030, 1'b0, 32'h0, 4'h0, 3'b000, {1'b0, 32'h1122_3344});
    wait_resp(lat, pn, an, st, sa, sw, ss, sd, sp);
    req_addr = 32'h4000_0000; req_write = 1'b1; req_wdata = 32'h5555_AAAA; req_wstrb = 4'h3;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({resp_valid, req_ready, out_psel, resp_err, resp_rdata} !== {3'b100, exp_q[0]}) begin
        n_bad++; $display("FAIL bp_hold%0d: valid/ready/psel=%b data=%h required 100/%h", i, {resp_valid, req_ready, out_psel}, {resp_err, resp_rdata}, exp_q[0]);
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    take_resp(got, e);
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL bp_resp: got %h required %h", got, e); end
    n_cmp++; if ({state_dbg, out_psel, req_ready, out_paddr} !== {2'd0, 1'b0, 1'b1, 32'h8000_0030}) begin n_bad++; $display("FAIL bp_no_capture: state=%0d psel=%b ready=%b addr=%h required 0/0/1/80000030", state_dbg, out_psel, req_ready, out_paddr); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int resps = 0;
    logic [32:0] got, e;
    slave_waits = 0; slave_hang = 0; slave_err = 0; slave_rdata = $urandom;
    req_addr = 32'h0000_0300; req_write = 1'b0; req_wstrb = 4'h0; req_prot = 3'b000;
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready === 1'b1) begin accepts++; exp_q.push_back({1'b0, slave_rdata}); end
      if (resp_valid === 1'b1) begin
        resps++;
        got = {resp_err, resp_rdata};
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL b2b_resp%0d: got %h required %h", resps, got, e); end
      end
      @(negedge clock);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    n_cmp++; if (accepts !== 3 || resps !== 3) begin n_bad++; $display("FAIL b2b_rate: accepts %0d responses %0d in 12 cycles required 3/3", accepts, resps); end
  endtask

  task automatic test_random();
    int lat, pn, an; bit st; logic [31:0] sa, sd; logic sw; logic [3:0] ss; logic [2:0] sp;
    logic [32:0] got, e;
    logic w; logic [3:0] strb; logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      w = 1'($urandom_range(0, 1)); strb = 4'($urandom_range(0, 15)); rd = $urandom;
      slave_waits = $urandom_range(0, 2); slave_err = 1'($urandom_range(0, 1)); slave_rdata = rd; slave_hang = 0;
      send_req($urandom, w, $urandom, strb, 3'($urandom_range(0, 7)), {slave_err, w ? 32'h0 : rd});
      wait_resp(lat, pn, an, st, sa, sw, ss, sd, sp);
      n_cmp++; if (lat !== 3 + slave_waits || ss !== (w ? strb : 4'h0)) begin n_bad++; $display("FAIL rnd_bus%0d: latency %0d strb %h required %0d/%h", i, lat, ss, 3 + slave_waits, w ? strb : 4'h0); end
      take_resp(got, e);
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL rnd_resp%0d: got %h required %h", i, got, e); end
    end
    slave_err = 0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    slave_hang = 1;
    send_req(32'h9000_0000, 1'b1, 32'h1357_9BDF, 4'hC, 3'b111, {1'b0, 32'h0});
    @(negedge clock);
    n_cmp++; if (out_penable !== 1'b1) begin n_bad++; $display("FAIL mid_in_access: penable=%b required 1", out_penable); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({out_psel, out_penable, resp_valid, req_ready} !== 4'b0000) begin n_bad++; $display("FAIL mid_abort: psel/penable/valid/ready=%b required 0000", {out_psel, out_penable, resp_valid, req_ready}); end
    n_cmp++; if (out_paddr !== 32'd0) begin n_bad++; $display("FAIL mid_addr_clear: addr=%h required 0", out_paddr); end
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0; slave_hang = 0;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: req_ready=%b required 1", req_ready); end
    for (int i = 0; i < 6; i++) begin
      if (resp_valid === 1'b1 || out_psel === 1'b1) seen++;
      @(negedge clock);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_stale: %0d cycles with resp_valid/psel required 0", seen); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL sb_drain: %0d expected responses left, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
